// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Packages : riscv, core
// Brief    : Shared encodings for the memory stage: instruction NOP, memory
//            op / ALU op / format enums, pipeline buses and MEM FSM states.
// Revision : 1.0 - initial release
// ============================================================================

package riscv;
  // Canonical NOP: addi x0, x0, 0
  localparam logic [31:0] I_NOP = 32'h0000_0013;
endpackage : riscv

package core;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    LB      = 4'd1,
    LH      = 4'd2,
    LW      = 4'd3,
    LBU     = 4'd4,
    LHU     = 4'd5,
    SB      = 4'd6,
    SH      = 4'd7,
    SW      = 4'd8
  } mem_op_t;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    NOP    = 3'd0,
    R_TYPE = 3'd1,
    I_TYPE = 3'd2,
    S_TYPE = 3'd3,
    B_TYPE = 3'd4,
    U_TYPE = 3'd5,
    J_TYPE = 3'd6
  } format_t;

  typedef struct packed {
    logic [31:0] instr;
    format_t     format;
    alu_op_t     alu_op;
    mem_op_t     mem_op;
    logic [4:0]  rd;
    logic [31:0] rd_res;
  } pipeline_bus_t;

  typedef struct packed {
    mem_op_t     mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cntrl_bus_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } bypass_bus_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_t;

  // Bubble inserted while the stage is stalled; also the reset value.
  localparam pipeline_bus_t BUBBLE_BUS = '{
    instr:  riscv::I_NOP,
    format: NOP,
    alu_op: ALU_NOP,
    mem_op: MEM_NOP,
    rd:     5'd0,
    rd_res: 32'd0
  };

  function automatic logic is_load(input mem_op_t op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // Formats that carry a destination register; x0 never counts as a write.
  function automatic logic writes_rd(input format_t fmt, input logic [4:0] rd);
    return ((fmt == R_TYPE) || (fmt == I_TYPE) || (fmt == U_TYPE) || (fmt == J_TYPE)) &&
           (rd != 5'd0);
  endfunction

endpackage : core
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Brief    : Combinational load-data aligner. Shifts the fetched word down to
//            the accessed byte lane and sign/zero-extends to 32 bits.
// Revision : 1.0 - initial release
// ============================================================================
module load_align
  import core::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  mem_op_t     i_mem_op,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_addr, 3'b000};

  // Pick the width of interest and extend according to the load flavour
  always_comb begin
    o_data = w_shifted;
    case (i_mem_op)
      LB:      o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LBU:     o_data = {24'd0, w_shifted[7:0]};
      LH:      o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LHU:     o_data = {16'd0, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule : load_align
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : Memory-access pipeline stage. Issues loads/stores over a
//            req/gnt/rvalid port, aligns load data, registers the result
//            towards write-back, and drives MEM bypass and upstream stall.
//            Optional macro MEM_STAGE_MISALIGN_TRAP_EN: misaligned H/W
//            accesses are dropped as a bubble and flagged on misalign_o;
//            otherwise low address bits are masked to natural alignment.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
  import core::*;
(
  input  logic           clk,
  input  logic           rst,
  input  pipeline_bus_t  bus_i,
  input  mem_cntrl_bus_t mem_i,
  output logic           dmem_req_o,
  output logic           dmem_we_o,
  output logic [31:0]    dmem_addr_o,
  output logic [3:0]     dmem_be_o,
  output logic [31:0]    dmem_wdata_o,
  input  logic           dmem_gnt_i,
  input  logic           dmem_rvalid_i,
  input  logic [31:0]    dmem_rdata_i,
  output logic           stall_o,
  output pipeline_bus_t  mem_bus_o,
  output bypass_bus_t    mem_bypass_o,
  output logic           misalign_o
);

  mem_state_t    r_state;
  pipeline_bus_t r_mem_bus;
  logic          r_misalign;

  logic          w_is_mem;
  logic          w_is_load;
  logic          w_is_store;
  logic          w_is_byte;
  logic          w_is_half;
  logic [1:0]    w_off;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_misalign;
  logic          w_issue;
  logic          w_resp;
  logic [31:0]   w_load_data;
  logic [31:0]   w_wb_data;
  logic          w_byp_valid;

  assign w_is_mem   = (mem_i.mem_op != MEM_NOP);
  assign w_is_load  = is_load(mem_i.mem_op);
  assign w_is_store = is_store(mem_i.mem_op);
  assign w_is_byte  = (mem_i.mem_op == LB) || (mem_i.mem_op == LBU) || (mem_i.mem_op == SB);
  assign w_is_half  = (mem_i.mem_op == LH) || (mem_i.mem_op == LHU) || (mem_i.mem_op == SH);

  // Lane offset, forced to the natural alignment of the access size
  always_comb begin
    w_off = mem_i.addr[1:0];
    if (w_is_half) begin
      w_off = {mem_i.addr[1], 1'b0};
    end else if (!w_is_byte) begin
      w_off = 2'b00;
    end
  end

  // Byte enables and lane-replicated store data for the access size
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_i.wdata;
    if (w_is_byte) begin
      w_be    = 4'b0001 << w_off;
      w_wdata = {4{mem_i.wdata[7:0]}};
    end else if (w_is_half) begin
      w_be    = 4'b0011 << w_off;
      w_wdata = {2{mem_i.wdata[15:0]}};
    end
  end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign w_misalign = (w_is_half && mem_i.addr[0]) ||
                      (w_is_mem && !w_is_byte && !w_is_half && (mem_i.addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue = (r_state == ST_IDLE) && w_is_mem && !w_misalign;
  assign w_resp  = (r_state == ST_WAIT) && dmem_rvalid_i;

  assign dmem_req_o   = !rst && (w_issue || (r_state == ST_REQ));
  assign dmem_we_o    = dmem_req_o && w_is_store;
  assign dmem_addr_o  = {mem_i.addr[31:2], 2'b00};
  assign dmem_be_o    = dmem_req_o ? w_be : 4'b0000;
  assign dmem_wdata_o = w_wdata;

  assign stall_o = !rst && (w_issue || (r_state == ST_REQ) ||
                            ((r_state == ST_WAIT) && !dmem_rvalid_i));

  load_align u_load_align (
    .i_rdata  (dmem_rdata_i),
    .i_addr   (w_off),
    .i_mem_op (mem_i.mem_op),
    .o_data   (w_load_data)
  );

  assign w_wb_data = w_is_load ? w_load_data : bus_i.rd_res;

  // A load can only forward once its data has actually returned
  assign w_byp_valid  = !rst && !w_misalign && writes_rd(bus_i.format, bus_i.rd) &&
                        (!w_is_load || w_resp);
  assign mem_bypass_o = w_byp_valid ? '{valid: 1'b1, rd: bus_i.rd, data: w_wb_data}
                                    : '0;

  // Access FSM plus the registered write-back bus and misalign flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_mem_bus  <= BUBBLE_BUS;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_is_mem) begin
            r_mem_bus <= BUBBLE_BUS;
            if (w_misalign) begin
              r_misalign <= 1'b1;
            end else begin
              r_state <= dmem_gnt_i ? ST_WAIT : ST_REQ;
            end
          end else begin
            r_mem_bus <= bus_i;
          end
        end
        ST_REQ: begin
          r_mem_bus <= BUBBLE_BUS;
          if (dmem_gnt_i) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dmem_rvalid_i) begin
            r_mem_bus        <= bus_i;
            r_mem_bus.rd_res <= w_wb_data;
            r_state          <= ST_IDLE;
          end else begin
            r_mem_bus <= BUBBLE_BUS;
          end
        end
        default: begin
          r_mem_bus <= BUBBLE_BUS;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_bus_o  = r_mem_bus;
  assign misalign_o = r_misalign;

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Directed, table-driven bench for mem_stage with hand-computed
//            expectations, plus reset, alignment and misalign sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
  import core::*;

  logic           clk;
  logic           rst;
  pipeline_bus_t  bus_i;
  mem_cntrl_bus_t mem_i;
  logic           dmem_req_o;
  logic           dmem_we_o;
  logic [31:0]    dmem_addr_o;
  logic [3:0]     dmem_be_o;
  logic [31:0]    dmem_wdata_o;
  logic           dmem_gnt_i;
  logic           dmem_rvalid_i;
  logic [31:0]    dmem_rdata_i;
  logic           stall_o;
  pipeline_bus_t  mem_bus_o;
  bypass_bus_t    mem_bypass_o;
  logic           misalign_o;

  int n_vec = 0;
  int n_err = 0;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .bus_i         (bus_i),
    .mem_i         (mem_i),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .stall_o       (stall_o),
    .mem_bus_o     (mem_bus_o),
    .mem_bypass_o  (mem_bypass_o),
    .misalign_o    (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    mem_op_t     op;
    format_t     fmt;
    logic [4:0]  rd;
    logic [31:0] rd_res;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    bit          stray;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input mem_op_t op, input format_t f,
                              input logic [4:0] rd, input logic [31:0] res,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rdat, input int g, input int r,
                              input bit s, input logic [3:0] be,
                              input logic [31:0] ew, input logic [31:0] er);
    vec_t v;
    v.name = n; v.op = op; v.fmt = f; v.rd = rd; v.rd_res = res;
    v.addr = addr; v.wdata = wd; v.rdata = rdat;
    v.gnt_dly = g; v.rv_dly = r; v.stray = s;
    v.exp_be = be; v.exp_wdata = ew; v.exp_res = er;
    return v;
  endfunction

  // One instruction through the stage; gnt after gnt_dly wait cycles,
  // rvalid after rv_dly further cycles. Entered just after a rising edge.
  task automatic run_op(input vec_t v);
    bit mem, ld, st, wr, in_req, last, exp_bv;
    int total, stalls;
    mem    = (v.op != MEM_NOP);
    ld     = v.op inside {LB, LH, LW, LBU, LHU};
    st     = v.op inside {SB, SH, SW};
    wr     = (v.fmt inside {R_TYPE, I_TYPE, U_TYPE, J_TYPE}) && (v.rd != 5'd0);
    total  = mem ? (v.gnt_dly + v.rv_dly + 2) : 1;
    stalls = 0;
    bus_i  = '{instr: 32'h00A0_0093, format: v.fmt, alu_op: ALU_ADD, mem_op: v.op,
               rd: v.rd, rd_res: v.rd_res};
    mem_i  = '{mem_op: v.op, addr: v.addr, wdata: v.wdata};
    for (int c = 0; c < total; c++) begin
      in_req        = mem && (c <= v.gnt_dly);
      last          = (c == total - 1);
      dmem_gnt_i    = in_req && (c == v.gnt_dly);
      dmem_rvalid_i = (mem && last) || (in_req && v.stray && (c != v.gnt_dly));
      dmem_rdata_i  = (mem && last) ? v.rdata : 32'hBAD0_BAD0;
      @(negedge clk);
      chk($sformatf("%s.req[%0d]", v.name, c), dmem_req_o, in_req);
      if (stall_o) stalls++;
      if (mem && c == 0) begin
        chk({v.name, ".be"}, dmem_be_o, v.exp_be);
        chk({v.name, ".addr"}, dmem_addr_o, {v.addr[31:2], 2'b00});
        chk({v.name, ".we"}, dmem_we_o, st);
        if (st) chk({v.name, ".wdata"}, dmem_wdata_o, v.exp_wdata);
      end
      if (c > 0) begin
        chk($sformatf("%s.bubble_rd[%0d]", v.name, c), mem_bus_o.rd, 5'd0);
        chk($sformatf("%s.bubble_instr[%0d]", v.name, c), mem_bus_o.instr, riscv::I_NOP);
      end
      exp_bv = wr && (!ld || last);
      chk($sformatf("%s.byp_valid[%0d]", v.name, c), mem_bypass_o.valid, exp_bv);
      if (exp_bv && last) begin
        chk({v.name, ".byp_rd"}, mem_bypass_o.rd, v.rd);
        chk({v.name, ".byp_data"}, mem_bypass_o.data, v.exp_res);
      end
      @(posedge clk); #1;
    end
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    chk({v.name, ".stall_cycles"}, stalls, total - 1);
    chk({v.name, ".wb_res"}, mem_bus_o.rd_res, v.exp_res);
    chk({v.name, ".wb_rd"}, mem_bus_o.rd, v.rd);
    chk({v.name, ".wb_fmt"}, mem_bus_o.format, v.fmt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = mk("alu_r5",  MEM_NOP, R_TYPE, 5'd5,  32'h0000_1234, 32'h0, 32'h0, 32'h0,
                  0, 0, 1'b0, 4'h0, 32'h0, 32'h0000_1234);
    vecs[1]  = mk("lb_103",  LB,  I_TYPE, 5'd6,  32'h0000_0103, 32'h103, 32'h0, 32'h80FF_FFFF,
                  0, 0, 1'b0, 4'h8, 32'h0, 32'hFFFF_FF80);
    vecs[2]  = mk("lbu_101", LBU, I_TYPE, 5'd7,  32'h0000_0101, 32'h101, 32'h0, 32'h1234_5678,
                  0, 0, 1'b0, 4'h2, 32'h0, 32'h0000_0056);
    vecs[3]  = mk("lh_002",  LH,  I_TYPE, 5'd8,  32'h0000_0002, 32'h002, 32'h0, 32'h8001_1234,
                  1, 0, 1'b0, 4'hC, 32'h0, 32'hFFFF_8001);
    vecs[4]  = mk("lhu_004", LHU, I_TYPE, 5'd9,  32'h0000_0004, 32'h004, 32'h0, 32'hDEAD_BEEF,
                  0, 2, 1'b0, 4'h3, 32'h0, 32'h0000_BEEF);
    vecs[5]  = mk("lw_008",  LW,  I_TYPE, 5'd10, 32'h0000_0008, 32'h008, 32'h0, 32'hCAFE_F00D,
                  0, 0, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D);
    vecs[6]  = mk("sb_011",  SB,  S_TYPE, 5'd0,  32'h0000_0077, 32'h011, 32'hFFFF_FFA5, 32'h0,
                  0, 0, 1'b0, 4'h2, 32'hA5A5_A5A5, 32'h0000_0077);
    vecs[7]  = mk("sh_202",  SH,  S_TYPE, 5'd0,  32'h0000_0088, 32'h202, 32'h1234_ABCD, 32'h0,
                  3, 0, 1'b1, 4'hC, 32'hABCD_ABCD, 32'h0000_0088);
    vecs[8]  = mk("sw_30c",  SW,  S_TYPE, 5'd0,  32'h0000_0099, 32'h30C, 32'h1122_3344, 32'h0,
                  0, 1, 1'b0, 4'hF, 32'h1122_3344, 32'h0000_0099);
    vecs[9]  = mk("alu_rd0", MEM_NOP, R_TYPE, 5'd0, 32'h0000_DEAD, 32'h0, 32'h0, 32'h0,
                  0, 0, 1'b0, 4'h0, 32'h0, 32'h0000_DEAD);
    vecs[10] = mk("i_r31",   MEM_NOP, I_TYPE, 5'd31, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0,
                  0, 0, 1'b0, 4'h0, 32'h0, 32'hFFFF_FFFF);
    vecs[11] = mk("lb_200",  LB,  I_TYPE, 5'd3,  32'h0000_0200, 32'h200, 32'h0, 32'hFFFF_FF7F,
                  2, 1, 1'b0, 4'h1, 32'h0, 32'h0000_007F);

    // Reset state, with a forwarding ALU op present to prove gating
    rst           = 1'b1;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;
    bus_i = '{instr: 32'h0000_0033, format: R_TYPE, alu_op: ALU_ADD, mem_op: MEM_NOP,
              rd: 5'd5, rd_res: 32'h1111_2222};
    mem_i = '{mem_op: MEM_NOP, addr: 32'h0, wdata: 32'h0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req", dmem_req_o, 1'b0);
    chk("rst.stall", stall_o, 1'b0);
    chk("rst.byp_valid", mem_bypass_o.valid, 1'b0);
    chk("rst.byp_data", mem_bypass_o.data, 32'h0);
    chk("rst.misalign", misalign_o, 1'b0);
    chk("rst.instr", mem_bus_o.instr, riscv::I_NOP);
    chk("rst.rd_res", mem_bus_o.rd_res, 32'h0);
    chk("rst.rd", mem_bus_o.rd, 5'd0);
    chk("rst.fmt", mem_bus_o.format, NOP);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table: consecutive entries also exercise back-to-back issue
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i]);
    end

`ifndef MEM_STAGE_MISALIGN_TRAP_EN
    // Misaligned halfword is masked to the upper half-word lane
    run_op(mk("lh_003m", LH, I_TYPE, 5'd4, 32'h0000_0003, 32'h003, 32'h0, 32'h7FFF_0000,
              0, 0, 1'b0, 4'hC, 32'h0, 32'h0000_7FFF));
`else
    // Misaligned word traps: no request, bubble out, one-cycle flag
    bus_i = '{instr: 32'h0060_2083, format: I_TYPE, alu_op: ALU_ADD, mem_op: LW,
              rd: 5'd12, rd_res: 32'h6};
    mem_i = '{mem_op: LW, addr: 32'h6, wdata: 32'h0};
    @(negedge clk);
    chk("mis.req", dmem_req_o, 1'b0);
    chk("mis.stall", stall_o, 1'b0);
    chk("mis.byp_valid", mem_bypass_o.valid, 1'b0);
    @(posedge clk); #1;
    chk("mis.flag", misalign_o, 1'b1);
    chk("mis.bubble_rd", mem_bus_o.rd, 5'd0);
    chk("mis.bubble_instr", mem_bus_o.instr, riscv::I_NOP);
    mem_i = '{mem_op: MEM_NOP, addr: 32'h0, wdata: 32'h0};
    bus_i.mem_op = MEM_NOP;
    @(posedge clk); #1;
    chk("mis.flag_clear", misalign_o, 1'b0);
`endif

    // Reset while waiting for a load response, then a stray rvalid
    bus_i = '{instr: 32'h0400_2483, format: I_TYPE, alu_op: ALU_ADD, mem_op: LW,
              rd: 5'd9, rd_res: 32'h0000_0055};
    mem_i = '{mem_op: LW, addr: 32'h40, wdata: 32'h0};
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    chk("rstw.req", dmem_req_o, 1'b1);
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    chk("rstw.req_in_rst", dmem_req_o, 1'b0);
    @(posedge clk); #1;
    rst           = 1'b0;
    mem_i         = '{mem_op: MEM_NOP, addr: 32'h40, wdata: 32'h0};
    bus_i.mem_op  = MEM_NOP;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h1234_5678;
    @(negedge clk);
    chk("rstw.req_after", dmem_req_o, 1'b0);
    chk("rstw.stall_after", stall_o, 1'b0);
    chk("rstw.bubble_rd", mem_bus_o.rd, 5'd0);
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0;
    chk("rstw.no_load_wb", mem_bus_o.rd_res, 32'h0000_0055);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mem_stage
`default_nettype wire
